// File: rtl/mario_dash_pkg.sv
// Shared level geometry and encodings for Mario Dash (physics engine and renderer).
package mario_dash_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CEIL_Y   = 75;
    localparam int LAVA_Y   = 380;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        AIRBORNE = 2'd1,
        DEAD     = 2'd2,
        WON      = 2'd3
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE, S_VEL, S_X_A, S_X_B, S_GND_A, S_GND_B, S_Y_A, S_Y_B, S_COMMIT
    } state_t;

    // Inclusive pixel bounds; goal marks the podium.
    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] x1;
        logic [9:0] y0;
        logic [9:0] y1;
        logic       goal;
    } rect_t;

    localparam int NUM_RECTS = 5;
    localparam rect_t [NUM_RECTS-1:0] LEVEL = '{
        '{10'd0,   10'd61,  10'd360, 10'd479, 1'b0},   // left step
        '{10'd160, 10'd260, 10'd300, 10'd309, 1'b0},   // floating platform
        '{10'd300, 10'd371, 10'd340, 10'd349, 1'b0},   // low ledge
        '{10'd400, 10'd431, 10'd230, 10'd379, 1'b0},   // tall block
        '{10'd580, 10'd630, 10'd355, 10'd360, 1'b1}    // gold podium
    };

endpackage

// File: rtl/platform_map.sv
// Combinational level lookup: is pixel (px, py) solid, and is it part of the goal podium.
module platform_map
    import mario_dash_pkg::*;
(
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       solid,
    output logic       goal
);

    always_comb begin
        solid = (py < 10'(CEIL_Y));
        goal  = 1'b0;
        if (px < 10'(SCREEN_W) && py < 10'(SCREEN_H)) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (px >= LEVEL[i].x0 && px <= LEVEL[i].x1 &&
                    py >= LEVEL[i].y0 && py <= LEVEL[i].y1) begin
                    solid = 1'b1;
                    if (LEVEL[i].goal) goal = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/player_physics.sv
// Per-frame player motion: velocity, pixel-stepped X / ground / Y collision, lava and goal, then commit.
// Up to 24 cycles per frame at defaults; define PLAYER_DOUBLE_JUMP_EN for one extra mid-air jump.
module player_physics #(
    parameter int START_X    = 20,
    parameter int START_Y    = 340,
    parameter int PLAYER_W   = 16,
    parameter int PLAYER_H   = 20,
    parameter int WALK_SPEED = 2,
    parameter int JUMP_VEL   = 9,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 8,
    parameter int LAVA_Y     = mario_dash_pkg::LAVA_Y
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [1:0] mode,
    output logic       busy
);
    import mario_dash_pkg::*;

    localparam logic [5:0] JUMP_V   = 6'(-JUMP_VEL);
    localparam logic [5:0] MAX_V    = 6'(MAX_FALL);
    localparam logic [5:0] GRAV_V   = 6'(GRAVITY);
    localparam logic [5:0] FALL_CAP = 6'(MAX_FALL - GRAVITY);
    localparam logic [9:0] X_MAX    = 10'(SCREEN_W - PLAYER_W);

    state_t     state_q, state_d;
    mode_t      wmode, mode_vel;
    logic [9:0] wx, wy, px, py;
    logic [5:0] vy, vy_vel, vy_mag, cnt;
    logic       l_q, r_q, j_q, hit_q, goal_q;
    logic       solid, goal, blocked_b, x_oob, moving_down;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic       dj_q;
`endif

    platform_map u_map (.px(px), .py(py), .solid(solid), .goal(goal));

    // Phase that follows the X walk: ground check only while standing.
    function automatic state_t after_x(input mode_t m, input logic [5:0] v);
        if (m == GROUNDED) return S_GND_A;
        else if (v != 6'd0) return S_Y_A;
        else return S_COMMIT;
    endfunction

    assign vy_mag      = vy[5] ? (~vy + 6'd1) : vy;
    assign moving_down = ~vy[5];
    assign blocked_b   = hit_q | solid;
    assign x_oob       = r_q ? (wx == X_MAX) : (wx == 10'd0);

    always_comb begin
        vy_vel   = vy;
        mode_vel = wmode;
        if (wmode == GROUNDED && j_q) begin
            vy_vel   = JUMP_V;
            mode_vel = AIRBORNE;
        end
`ifdef PLAYER_DOUBLE_JUMP_EN
        else if (wmode == AIRBORNE && j_q && dj_q) begin
            vy_vel = JUMP_V;
        end
`endif
        else if (wmode == AIRBORNE) begin
            vy_vel = ($signed(vy) >= $signed(FALL_CAP)) ? MAX_V : vy + GRAV_V;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_tick && (wmode == GROUNDED || wmode == AIRBORNE)) state_d = S_VEL;
            S_VEL:    state_d = (l_q ^ r_q) ? S_X_A : after_x(mode_vel, vy_vel);
            S_X_A:    state_d = S_X_B;
            S_X_B:    state_d = (blocked_b || cnt == 6'(WALK_SPEED - 1)) ? after_x(wmode, vy) : S_X_A;
            S_GND_A:  state_d = S_GND_B;
            S_GND_B:  state_d = S_COMMIT;
            S_Y_A:    state_d = S_Y_B;
            S_Y_B:    state_d = (blocked_b || cnt == vy_mag - 6'd1) ? S_COMMIT : S_Y_A;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Probe address for the current collision cycle; A/B are the two corners of the leading edge.
    always_comb begin
        px   = wx;
        py   = wy;
        busy = (state_q != S_IDLE);
        case (state_q)
            S_X_A:   px = r_q ? wx + 10'(PLAYER_W) : wx - 10'd1;
            S_X_B: begin
                px = r_q ? wx + 10'(PLAYER_W) : wx - 10'd1;
                py = wy + 10'(PLAYER_H - 1);
            end
            S_GND_A: py = wy + 10'(PLAYER_H);
            S_GND_B: begin
                px = wx + 10'(PLAYER_W - 1);
                py = wy + 10'(PLAYER_H);
            end
            S_Y_A:   py = moving_down ? wy + 10'(PLAYER_H) : wy - 10'd1;
            S_Y_B: begin
                px = wx + 10'(PLAYER_W - 1);
                py = moving_down ? wy + 10'(PLAYER_H) : wy - 10'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            player_x <= 10'(START_X);
            player_y <= 10'(START_Y);
            mode     <= GROUNDED;
            wx       <= 10'(START_X);
            wy       <= 10'(START_Y);
            wmode    <= GROUNDED;
            vy       <= 6'd0;
            cnt      <= 6'd0;
            {l_q, r_q, j_q, hit_q, goal_q} <= '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (frame_tick) begin
                    {l_q, r_q, j_q} <= {btn_left, btn_right, btn_jump};
                    if ((wmode == DEAD || wmode == WON) && btn_jump) begin
                        player_x <= 10'(START_X);
                        player_y <= 10'(START_Y);
                        mode     <= GROUNDED;
                        wx       <= 10'(START_X);
                        wy       <= 10'(START_Y);
                        wmode    <= GROUNDED;
                        vy       <= 6'd0;
`ifdef PLAYER_DOUBLE_JUMP_EN
                        dj_q     <= 1'b1;
`endif
                    end
                end
                S_VEL: begin
                    vy    <= vy_vel;
                    wmode <= mode_vel;
                    cnt   <= 6'd0;
`ifdef PLAYER_DOUBLE_JUMP_EN
                    if (wmode == AIRBORNE && j_q) dj_q <= 1'b0;
`endif
                end
                S_X_A: hit_q <= x_oob | solid;
                S_X_B: begin
                    if (!blocked_b) wx <= r_q ? wx + 10'd1 : wx - 10'd1;
                    cnt <= (state_d == S_X_A) ? cnt + 6'd1 : 6'd0;
                end
                S_GND_A: hit_q <= solid;
                S_GND_B: if (!blocked_b) begin
                    wmode <= AIRBORNE;
                    vy    <= 6'd0;
                end
                S_Y_A: begin
                    hit_q  <= solid;
                    goal_q <= goal;
                end
                S_Y_B: begin
                    if (blocked_b) begin
                        vy <= 6'd0;
                        if (moving_down) begin
                            wmode <= (goal_q | goal) ? WON : GROUNDED;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            dj_q  <= 1'b1;
`endif
                        end
                    end else begin
                        wy <= moving_down ? wy + 10'd1 : wy - 10'd1;
                    end
                    cnt <= (state_d == S_Y_A) ? cnt + 6'd1 : 6'd0;
                end
                S_COMMIT: begin
                    player_x <= wx;
                    player_y <= wy;
                    if (wy + 10'(PLAYER_H - 1) >= 10'(LAVA_Y)) begin
                        mode  <= DEAD;
                        wmode <= DEAD;
                    end else begin
                        mode  <= wmode;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics with a frame-level reference model and per-cycle output compare.
module tb_player_physics;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic [9:0] player_x, player_y;
    logic [1:0] mode;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // committed model state (m_) and the result of the frame in flight (n_)
    int m_x = 20, m_y = 340, m_mode = 0, m_vy = 0, m_dj = 1;
    int n_x = 20, n_y = 340, n_mode = 0, n_vy = 0, n_dj = 1;
    int lat = 0;
    bit in_flight = 1'b0;
    bit chk_en = 1'b0;

    player_physics dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .player_x(player_x), .player_y(player_y), .mode(mode), .busy(busy)
    );

    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Level as plain rectangles: {x0, x1, y0, y1, goal}
    function automatic bit in_rect(int x, int y, int x0, int x1, int y0, int y1);
        return x >= x0 && x <= x1 && y >= y0 && y <= y1;
    endfunction

    function automatic bit goalp(int x, int y);
        return in_rect(x, y, 580, 630, 355, 360);
    endfunction

    function automatic bit solid(int x, int y);
        if (y < 75) return 1'b1;
        return in_rect(x, y, 0, 61, 360, 479) || in_rect(x, y, 160, 260, 300, 309) ||
               in_rect(x, y, 300, 371, 340, 349) || in_rect(x, y, 400, 431, 230, 379) ||
               goalp(x, y);
    endfunction

    task automatic model_frame(input bit l, input bit r, input bit j);
        int dir, steps;
        n_x = m_x; n_y = m_y; n_mode = m_mode; n_vy = m_vy; n_dj = m_dj;
        lat = 0;
        if (m_mode == 2 || m_mode == 3) begin
            if (j) begin
                n_x = 20; n_y = 340; n_mode = 0; n_vy = 0; n_dj = 1;
            end
            return;
        end
        if (m_mode == 0 && j) begin
            n_vy = -9; n_mode = 1;
        end
`ifdef PLAYER_DOUBLE_JUMP_EN
        else if (m_mode == 1 && j && m_dj == 1) begin
            n_vy = -9; n_dj = 0;
        end
`endif
        else if (m_mode == 1) begin
            n_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
        end
        lat = 1;
        dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        if (dir != 0) begin
            for (int i = 0; i < 2; i++) begin
                int col;
                lat += 2;
                if (n_x + dir < 0 || n_x + dir > 624) break;
                col = (dir > 0) ? n_x + 16 : n_x - 1;
                if (solid(col, n_y) || solid(col, n_y + 19)) break;
                n_x += dir;
            end
        end
        if (n_mode == 0) begin
            lat += 2;
            if (!solid(n_x, n_y + 20) && !solid(n_x + 15, n_y + 20)) begin
                n_mode = 1; n_vy = 0;
            end
        end
        steps = (n_vy < 0) ? -n_vy : n_vy;
        for (int i = 0; i < steps; i++) begin
            int row;
            lat += 2;
            row = (n_vy > 0) ? n_y + 20 : n_y - 1;
            if (solid(n_x, row) || solid(n_x + 15, row)) begin
                if (n_vy > 0) begin
                    n_mode = (goalp(n_x, row) || goalp(n_x + 15, row)) ? 3 : 0;
                    n_dj = 1;
                end
                n_vy = 0;
                break;
            end
            n_y += (n_vy > 0) ? 1 : -1;
        end
        lat += 1;
        if (n_y + 19 >= 380) n_mode = 2;
    endtask

    // Committed outputs must hold the old frame while busy, and the new one once idle.
    always @(negedge clk) begin
        if (chk_en && rst) begin
            if (in_flight && !busy) begin
                chk("x", int'(player_x), n_x);
                chk("y", int'(player_y), n_y);
                chk("mode", int'(mode), n_mode);
            end else begin
                chk("x", int'(player_x), m_x);
                chk("y", int'(player_y), m_y);
                chk("mode", int'(mode), m_mode);
            end
            if (!in_flight) chk("idle_busy", int'(busy), 0);
        end
    end

    task automatic do_tick(input bit l, input bit r, input bit j, input bit dbl);
        int cnt;
        bit done;
        @(posedge clk); #1;
        btn_left = l; btn_right = r; btn_jump = j; frame_tick = 1'b1;
        model_frame(l, r, j);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        in_flight = 1'b1;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            cnt++;
            if (dbl) frame_tick = (cnt == 2);
        end
        frame_tick = 1'b0;
        if (!done) chk("busy_timeout", 1, 0);
        chk("latency", cnt, lat);
        m_x = n_x; m_y = n_y; m_mode = n_mode; m_vy = n_vy; m_dj = n_dj;
        in_flight = 1'b0;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_x", int'(player_x), 20);
        chk("reset_y", int'(player_y), 340);
        chk("reset_mode", int'(mode), 0);
        chk("reset_busy", int'(busy), 0);
        chk_en = 1'b1;

        // walk right, then both buttons
        do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("walk_latency_pin", lat, 8);
        repeat (9) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("walk_x", int'(player_x), 40);
        chk("walk_mode", int'(mode), 0);
        repeat (2) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_x", int'(player_x), 40);
        repeat (10) do_tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("back_x", int'(player_x), 20);

        // jump arc
        do_tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("jump_t1_y", int'(player_y), 331);
        chk("jump_t1_mode", int'(mode), 1);
        repeat (8) do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("jump_t9_y", int'(player_y), 295);
        repeat (11) do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("land_y", int'(player_y), 340);
        chk("land_mode", int'(mode), 0);

`ifdef PLAYER_DOUBLE_JUMP_EN
        do_tick(1'b0, 1'b0, 1'b1, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dj_t3_y", int'(player_y), 314);
        do_tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dj_t4_y", int'(player_y), 306);
        for (int i = 0; i < 40 && m_mode != 0; i++) do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("dj_land_mode", int'(mode), 0);
`endif

        // second tick during busy is ignored
        do_tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("dbl_tick_x", int'(player_x), 22);
        repeat (5) @(negedge clk);

        // reset in the middle of an update
        chk_en = 1'b0;
        @(posedge clk); #1;
        btn_right = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_x", int'(player_x), 20);
        chk("mid_rst_y", int'(player_y), 340);
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_busy", int'(busy), 0);
        m_x = 20; m_y = 340; m_mode = 0; m_vy = 0; m_dj = 1;
        rst = 1'b1;
        btn_right = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        // off the ledge into the lava
        repeat (21) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ledge_x", int'(player_x), 62);
        chk("ledge_mode", int'(mode), 1);
        repeat (6) do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("dead_mode", int'(mode), 2);
        chk("dead_y", int'(player_y), 361);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("frozen_x", int'(player_x), 62);
        do_tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("respawn_x", int'(player_x), 20);
        chk("respawn_y", int'(player_y), 340);
        chk("respawn_mode", int'(mode), 0);

        // left screen edge
        repeat (12) do_tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("left_edge_x", int'(player_x), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
